// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: reset vector, bubble encoding and
// the IF/ID bundle consumed by the decode stage.
package mips_pkg;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;  // sll $0,$0,0

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

  function automatic if_id_t if_id_bubble();
    if_id_t b;
    b.valid    = 1'b0;
    b.inst     = NOP_INST;
    b.pc       = 32'h0;
    b.pc_plus4 = 32'h0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, hazard/redirect controls and the
// IF/ID outputs toward decode.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        flush;
  logic        if_id_valid;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;

  modport master (
    output imem_addr,
    input  imem_inst,
    input  stall,
    input  redirect_valid,
    input  redirect_target,
    input  flush,
    output if_id_valid,
    output if_id_inst,
    output if_id_pc,
    output if_id_pc_plus4
  );

  modport slave (
    input  imem_addr,
    output imem_inst,
    output stall,
    output redirect_valid,
    output redirect_target,
    output flush,
    input  if_id_valid,
    input  if_id_inst,
    input  if_id_pc,
    input  if_id_pc_plus4
  );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall holds, otherwise load.
module if_id_reg
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   flush,
  input  logic   stall,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= if_id_bubble();
    end else if (flush) begin
      q <= if_id_bubble();
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID
// register feeding decode.
module fetch_stage
  import mips_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  if_id_t      fetch_word;
  if_id_t      if_id_q;
  logic        unused_target_lsbs;

  assign pc_plus4 = pc_q + 32'd4;

  // NOTE: always_comb assigns a default before any branch so no path leaves pc_d unassigned (no latch).
  always_comb begin
    pc_d = pc_plus4;
    if (bus.redirect_valid) begin
      pc_d = {bus.redirect_target[31:2], 2'b00};
    end else if (bus.stall) begin
      pc_d = pc_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.imem_addr = pc_q;

  assign fetch_word.valid    = 1'b1;
  assign fetch_word.inst     = bus.imem_inst;
  assign fetch_word.pc       = pc_q;
  assign fetch_word.pc_plus4 = pc_plus4;

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .reset (reset),
    .flush (bus.flush),
    .stall (bus.stall),
    .d     (fetch_word),
    .q     (if_id_q)
  );

  assign bus.if_id_valid    = if_id_q.valid;
  assign bus.if_id_inst     = if_id_q.inst;
  assign bus.if_id_pc       = if_id_q.pc;
  assign bus.if_id_pc_plus4 = if_id_q.pc_plus4;

  // Redirect targets are word-aligned by truncation; the low bits are ignored.
  assign unused_target_lsbs = ^bus.redirect_target[1:0];

endmodule
